// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the sequential BCD to excess-3 converter.
package bcd_xs3_pkg;

  // Controller states: waiting for a word, converting digits, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Excess-3 offset added to every BCD digit
  localparam logic [3:0] XS3_OFFSET = 4'd3;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // 4-bit excess-3 sum with the carry dropped
  function automatic logic [3:0] xs3_of(input logic [3:0] d);
    return d + XS3_OFFSET;
  endfunction

endpackage

// File: rtl/bcd_digit_xs3.sv
// Single-digit BCD to excess-3 converter, purely combinational.
// invalid_o flags a digit above 9; it is only driven when BCD_XS3_ERR_CHECK_EN
// is defined and is constant 0 otherwise.
module bcd_digit_xs3
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] xs3_o,
  output logic       invalid_o
);

  // Data path: mod-16 add of the excess-3 offset
  always_comb begin
    xs3_o = xs3_of(bcd_i);
  end

`ifdef BCD_XS3_ERR_CHECK_EN
  // Range check against the largest legal BCD digit
  always_comb begin
    invalid_o = (bcd_i > BCD_MAX);
  end
`else
  // No range checking in this build
  always_comb begin
    invalid_o = 1'b0;
  end
`endif

endmodule

// File: rtl/bcd_xs3_seq.sv
// Sequential packed BCD to excess-3 converter.
// A captured word is converted one digit per clock (LSB digit first) through a
// single shared bcd_digit_xs3 instance; the finished word is held on out_xs3
// until the downstream side accepts it.
// Optional feature: define BCD_XS3_ERR_CHECK_EN to flag digits greater than 9
// on out_err; without it out_err is constant 0.
module bcd_xs3_seq
  import bcd_xs3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [4*DIGITS-1:0]    src_q;
  logic [4*DIGITS-1:0]    work_q;
  logic [4*DIGITS-1:0]    work_d;
  logic [4*DIGITS-1:0]    out_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   in_ready_q;

  logic [3:0]             cur_bcd;
  logic [3:0]             cur_xs3;
  logic                   cur_invalid;
  logic                   last_idx;

`ifdef BCD_XS3_ERR_CHECK_EN
  logic                   err_q;
`endif

  // Select source digit idx for the shared converter
  always_comb begin
    cur_bcd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_bcd = src_q[4*i +: 4];
      end
    end
  end

  bcd_digit_xs3 u_digit (
    .bcd_i     (cur_bcd),
    .xs3_o     (cur_xs3),
    .invalid_o (cur_invalid)
  );

  // Working result with the converted digit written into slot idx
  always_comb begin
    work_d = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        work_d[4*i +: 4] = cur_xs3;
      end
    end
  end

  // Final digit of the word is being converted this cycle
  always_comb begin
    last_idx = (idx_q == LAST_IDX);
  end

  // Controller FSM with registered handshake and status outputs.
  // Digits accumulate in work_q so out_xs3 keeps the previous word until the
  // new one is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      src_q       <= '0;
      work_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef BCD_XS3_ERR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            src_q      <= in_bcd;
            idx_q      <= '0;
            work_q     <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= CONV;
`ifdef BCD_XS3_ERR_CHECK_EN
            err_q      <= 1'b0;
`endif
          end
        end
        CONV: begin
          work_q <= work_d;
`ifdef BCD_XS3_ERR_CHECK_EN
          err_q  <= err_q | cur_invalid;
`endif
          if (last_idx) begin
            out_q       <= work_d;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Output drive; in_ready is masked by rst so no word is taken during reset
  always_comb begin
    in_ready  = in_ready_q & ~rst;
    out_valid = out_valid_q;
    out_xs3   = out_q;
    busy      = busy_q;
`ifdef BCD_XS3_ERR_CHECK_EN
    out_err   = err_q;
`else
    // cur_invalid is constant 0 in this build
    out_err   = cur_invalid;
`endif
  end

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Scoreboard bench for bcd_xs3_seq with DIGITS = 4.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge and pops the expected word on every accepted output.
module tb_bcd_xs3_seq;

  localparam int unsigned DIGITS = 4;

`ifdef BCD_XS3_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] in_bcd;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_xs3;
  logic                out_err;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int acc [3];

  logic [16:0] sb_q [$];

  bcd_xs3_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Monitor: every accepted output word is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no output (cycle %0d)", out_xs3, cyc);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        check("out_xs3", {16'h0, out_xs3}, {16'h0, e[15:0]});
        check("out_err", {31'h0, out_err}, {31'h0, e[16]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    check("in_ready_wait", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    check("out_valid_wait", {31'h0, out_valid}, 32'h1);
  endtask

  // Offer one word, push its expectation, return one unit after acceptance
  task automatic send(input logic [15:0] bcd, input logic [15:0] xs3, input bit err);
    wait_in_ready();
    in_valid = 1'b1;
    in_bcd   = bcd;
    sb_q.push_back({err & ERR_ON, xs3});
    last_acc = cyc + 1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("drain", sb_q.size(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 16'h9999;
    out_ready = 1'b0;
    tick(); tick(); tick();

    // Reset state, with in_valid asserted during reset
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_xs3",   {16'h0, out_xs3},   32'h0);
    check("rst_out_err",   {31'h0, out_err},   32'h0);
    check("rst_busy",      {31'h0, busy},      32'h0);
    check("rst_in_ready",  {31'h0, in_ready},  32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_fall_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check("no_capture_in_rst", {31'h0, busy}, 32'h0);

    // 1: basic word, latency and return to IDLE
    out_ready = 1'b1;
    send(16'h1234, 16'h4567, 1'b0);
    check("conv_busy",     {31'h0, busy},     32'h1);
    check("conv_in_ready", {31'h0, in_ready}, 32'h0);
    wait_out_valid();
    check("latency", cyc - last_acc, 32'd4);
    tick();
    check("idle_in_ready", {31'h0, in_ready},  32'h1);
    check("idle_out_valid", {31'h0, out_valid}, 32'h0);
    drain();

    // 2: boundary digits
    send(16'h0000, 16'h3333, 1'b0);
    send(16'h9999, 16'hCCCC, 1'b0);
    drain();

    // 3: backpressure in DONE, new offer ignored
    out_ready = 1'b0;
    send(16'h5678, 16'h89AB, 1'b0);
    wait_out_valid();
    in_valid = 1'b1;
    in_bcd   = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_out_xs3",   {16'h0, out_xs3},   32'h89AB);
      check("bp_in_ready",  {31'h0, in_ready},  32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", {31'h0, in_ready},  32'h1);
    check("bp_release_valid",    {31'h0, out_valid}, 32'h0);
    check("bp_release_busy",     {31'h0, busy},      32'h0);
    drain();

    // 4: digits above 9
    send(16'h12A4, 16'h45D7, 1'b1);
    send(16'h0D00, 16'h3033, 1'b1);
    drain();

    // 5: reset after two CONV cycles
    send(16'h4321, 16'h7654, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_out_xs3",   {16'h0, out_xs3},   32'h0);
    check("mid_rst_busy",      {31'h0, busy},      32'h0);
    check("mid_rst_in_ready",  {31'h0, in_ready},  32'h0);
    sb_q.delete();
    rst = 1'b0;
    #1;
    check("mid_rst_fall_in_ready", {31'h0, in_ready}, 32'h1);
    send(16'h0042, 16'h3375, 1'b0);
    drain();

    // 6: back-to-back streaming
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] w;
      w = 16'(i + 1);
      wait_in_ready();
      in_bcd = w;
      sb_q.push_back({1'b0, 16'h3333 + w});
      acc[i] = cyc + 1;
      tick();
    end
    in_valid = 1'b0;
    check("stream_gap0", acc[1] - acc[0], 32'd6);
    check("stream_gap1", acc[2] - acc[1], 32'd6);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
